// File: rtl/draw_cmd_pkg.sv
// draw_cmd_pkg
// Shared definitions for the draw command executor: command codes (matching
// the draw sequencer encoding), default screen geometry, the rectangle record,
// the executor FSM state type, and the command-to-rectangle lookup.
//
// The table entries are all within the 160x120 screen, so the default build of
// the executor needs no clipping.
package draw_cmd_pkg;

  localparam int SCR_W_DEF = 160;
  localparam int SCR_H_DEF = 120;

  localparam logic [4:0] CMD_CLEAR_0     = 5'd0;
  localparam logic [4:0] CMD_CLEAR_1     = 5'd1;
  localparam logic [4:0] CMD_NOTE_FIRST  = 5'd2;
  localparam logic [4:0] CMD_NOTE_LAST   = 5'd16;
  localparam logic [4:0] CMD_SIDE_TOP    = 5'd17;
  localparam logic [4:0] CMD_SIDE_BOT    = 5'd18;
  localparam logic [4:0] CMD_BACKGROUND  = 5'd19;
  localparam logic [4:0] CMD_PLAY_CLEAR  = 5'd20;
  localparam logic [4:0] CMD_NOP_A       = 5'd21;
  localparam logic [4:0] CMD_NOP_B       = 5'd22;
  localparam logic [4:0] CMD_BAR_LEFT    = 5'd23;
  localparam logic [4:0] CMD_BAR_RIGHT   = 5'd24;
  localparam logic [4:0] CMD_BAR_MID     = 5'd25;
  localparam logic [4:0] CMD_ILLEGAL_MIN = 5'd26;

  typedef struct packed {
    logic [7:0] x0;
    logic [6:0] y0;
    logic [7:0] w;
    logic [6:0] h;
    logic [2:0] col;
  } rect_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DRAW = 2'd2,
    ST_DONE = 2'd3
  } exec_state_t;

  function automatic logic is_illegal(input logic [4:0] cmd);
    return (cmd >= CMD_ILLEGAL_MIN);
  endfunction

  function automatic logic is_noop(input logic [4:0] cmd);
    return (cmd == CMD_NOP_A) || (cmd == CMD_NOP_B) || is_illegal(cmd);
  endfunction

  // No-op codes return an all-zero rectangle; it is never rastered.
  function automatic rect_t cmd_to_rect(input logic [4:0] cmd, input logic [1:0] choose);
    rect_t r;
    r = '0;
    if ((cmd >= CMD_NOTE_FIRST) && (cmd <= CMD_NOTE_LAST)) begin
      // Note blocks sit on a 10-pixel pitch starting at column 5.
      r.x0  = 8'd5 + (8'd10 * 8'(cmd - CMD_NOTE_FIRST));
      r.y0  = 7'd40;
      r.w   = 8'd8;
      r.h   = 7'd4;
      r.col = 3'b110;
    end else begin
      case (cmd)
        CMD_CLEAR_0:    begin r.w = 8'd160; r.h = 7'd120; r.col = 3'b000; end
        CMD_CLEAR_1:    begin r.w = 8'd160; r.h = 7'd120; r.col = 3'b001; end
        CMD_SIDE_TOP:   begin r.x0 = 8'd140; r.w = 8'd20; r.h = 7'd15; r.col = 3'b010; end
        CMD_SIDE_BOT:   begin r.x0 = 8'd140; r.y0 = 7'd15; r.w = 8'd20; r.h = 7'd15; r.col = 3'b010; end
        CMD_BACKGROUND: begin
          r.w = 8'd160;
          r.h = 7'd120;
          case (choose)
            2'b00:   r.col = 3'b000;
            2'b01:   r.col = 3'b001;
            2'b10:   r.col = 3'b011;
            default: r.col = 3'b100;
          endcase
        end
        CMD_PLAY_CLEAR: begin r.y0 = 7'd60; r.w = 8'd160; r.h = 7'd1; r.col = 3'b000; end
        CMD_BAR_LEFT:   begin r.x0 = 8'd30; r.y0 = 7'd44; r.w = 8'd1; r.h = 7'd32; r.col = 3'b011; end
        CMD_BAR_RIGHT:  begin r.x0 = 8'd38; r.y0 = 7'd44; r.w = 8'd1; r.h = 7'd32; r.col = 3'b011; end
        CMD_BAR_MID:    begin r.x0 = 8'd34; r.y0 = 7'd44; r.w = 8'd1; r.h = 7'd32; r.col = 3'b101; end
        default:        r = '0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/draw_rect_raster.sv
// draw_rect_raster
// Row-major scanner over a w x h rectangle, one pixel per cycle.
// Ports:
//   CLK, reset   clock, synchronous active-low reset (clears active only)
//   start        pulse: clear counters and begin scanning next cycle
//   x0, y0, w, h rectangle origin and size (held stable while active)
//   x, y         9-bit coordinate sums x0+cx, y0+cy
//   active       high while a pixel is being presented
//   last         high on the final pixel (cx=w-1, cy=h-1)
module draw_rect_raster (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] x0,
  input  logic [6:0] y0,
  input  logic [7:0] w,
  input  logic [6:0] h,
  output logic [8:0] x,
  output logic [8:0] y,
  output logic       active,
  output logic       last
);

  logic [7:0] cx;
  logic [6:0] cy;
  logic       row_end;

  assign row_end = (cx == (w - 8'd1));
  assign last    = active && row_end && (cy == (h - 7'd1));
  assign x       = {1'b0, x0} + {1'b0, cx};
  assign y       = {2'b00, y0} + {2'b00, cy};

  always_ff @(posedge CLK) begin
    if (!reset)     active <= 1'b0;
    else if (start) active <= 1'b1;
    else if (last)  active <= 1'b0;
  end

  // Counters need no reset: start always clears them before use.
  always_ff @(posedge CLK) begin
    if (start) begin
      cx <= 8'd0;
      cy <= 7'd0;
    end else if (active) begin
      if (row_end) begin
        cx <= 8'd0;
        cy <= cy + 7'd1;
      end else begin
        cx <= cx + 8'd1;
      end
    end
  end

endmodule

// File: rtl/draw_command_executor.sv
// draw_command_executor
// Accepts 5-bit draw commands over a valid/ready handshake, looks up the
// rectangle and colour for each, and rasterizes it into per-pixel writes for
// the 160x120 3-bit framebuffer adapter. Flow: IDLE -> LOAD -> DRAW -> DONE.
// Ports:
//   CLK, reset          clock, synchronous active-low reset
//   cmd_valid, cmd      command handshake input and code
//   choose              background palette select, captured with cmd
//   cmd_ready           high only in IDLE
//   x, y, colour, plot  pixel write; x/y/colour hold outside DRAW
//   done                one-cycle completion pulse
//   err                 sticky flag: an illegal code (26..31) was accepted
// Configuration:
//   DRAW_EXEC_CLIP_EN   when defined, pixels outside SCR_W x SCR_H are
//                       suppressed (plot=0) without changing timing.
module draw_command_executor
  import draw_cmd_pkg::*;
#(
  parameter int SCR_W = SCR_W_DEF,
  parameter int SCR_H = SCR_H_DEF
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [4:0] cmd,
  input  logic [1:0] choose,
  output logic       cmd_ready,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       done,
  output logic       err
);

  exec_state_t state, state_nx;
  logic [4:0]  cmd_q;
  logic [1:0]  choose_q;
  rect_t       rect_q;
  logic [7:0]  x_q;
  logic [6:0]  y_q;
  logic [2:0]  col_q;
  logic        start;
  logic        in_draw;
  logic        pix_ok;
  logic [8:0]  ras_x;
  logic [8:0]  ras_y;
  logic        ras_active;
  logic        ras_last;

  draw_rect_raster u_raster (
    .CLK    (CLK),
    .reset  (reset),
    .start  (start),
    .x0     (rect_q.x0),
    .y0     (rect_q.y0),
    .w      (rect_q.w),
    .h      (rect_q.h),
    .x      (ras_x),
    .y      (ras_y),
    .active (ras_active),
    .last   (ras_last)
  );

  always_ff @(posedge CLK) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    case (state)
      ST_IDLE: if (cmd_valid) state_nx = ST_LOAD;
      ST_LOAD: begin
        if (is_noop(cmd_q)) begin
          state_nx = ST_DONE;
        end else begin
          state_nx = ST_DRAW;
          start    = 1'b1;
        end
      end
      ST_DRAW: if (ras_last && ras_active) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Command capture and table lookup are data; only control is reset.
  always_ff @(posedge CLK) begin
    if ((state == ST_IDLE) && cmd_valid) begin
      cmd_q    <= cmd;
      choose_q <= choose;
    end
    if (state == ST_LOAD) rect_q <= cmd_to_rect(cmd_q, choose_q);
  end

  always_ff @(posedge CLK) begin
    if (!reset)                                     err <= 1'b0;
    else if ((state == ST_LOAD) && is_illegal(cmd_q)) err <= 1'b1;
  end

  // Hold registers give x/y/colour their value outside DRAW.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      x_q   <= 8'd0;
      y_q   <= 7'd0;
      col_q <= 3'd0;
    end else if (in_draw) begin
      x_q   <= ras_x[7:0];
      y_q   <= ras_y[6:0];
      col_q <= rect_q.col;
    end
  end

`ifdef DRAW_EXEC_CLIP_EN
  assign pix_ok = (ras_x < 9'(SCR_W)) && (ras_y < 9'(SCR_H));
`else
  logic clip_unused;
  assign clip_unused = &{1'b0, ras_x[8], ras_y[8:7], SCR_W[0], SCR_H[0]};
  assign pix_ok      = 1'b1;
`endif

  assign in_draw   = (state == ST_DRAW);
  assign cmd_ready = (state == ST_IDLE);
  assign done      = (state == ST_DONE);
  assign plot      = in_draw && pix_ok;
  assign x         = in_draw ? ras_x[7:0] : x_q;
  assign y         = in_draw ? ras_y[6:0] : y_q;
  assign colour    = in_draw ? rect_q.col : col_q;

endmodule

// File: doc/draw_command_executor.md
# draw_command_executor

Consumes the 5-bit draw commands produced by the draw sequencer and rasterizes each one into per-pixel writes for the 160x120, 3-bit-colour VGA framebuffer adapter. Each legal command maps to one fixed rectangle and colour. The block scans that rectangle row-major at one pixel per cycle, drives `x`/`y`/`colour`/`plot`, and signals completion. A valid/ready handshake replaces fixed-duration command holding.

## Interface
Parameters:
- SCR_W, 160, screen width in pixels
- SCR_H, 120, screen height in pixels

Ports:
- CLK  in  1  clock
- reset  in  1  synchronous, active-low
- cmd_valid  in  1  command present
- cmd  in  5  command code
- choose  in  2  background palette select, sampled with cmd
- cmd_ready  out  1  block idle, can accept
- x  out  8  pixel column
- y  out  7  pixel row
- colour  out  3  pixel colour
- plot  out  1  write strobe for current x/y/colour
- done  out  1  one-cycle pulse: command finished
- err  out  1  sticky: illegal command received

## Operation
- Reset (reset==0 at an edge): state IDLE, cmd_ready=1, plot=0, done=0, err=0, x=0, y=0, colour=0.
- FSM states: IDLE -> LOAD -> DRAW -> DONE -> IDLE. No-op commands go LOAD -> DONE.
- IDLE: cmd_ready=1. When cmd_valid & cmd_ready, capture cmd and choose and go to LOAD. cmd_ready is 0 in all other states; cmd_valid is ignored there.
- LOAD: table lookup registered into x0, y0, w, h, col. Clear the row/column counters.
- DRAW: x=x0+cx, y=y0+cy, colour=col, plot=1. cx increments each cycle. At cx=w-1, cx wraps to 0 and cy increments. After (cx,cy)=(w-1,h-1), go to DONE.
- DONE: done=1 for one cycle, plot=0, then IDLE.
- Command table (x0,y0,w,h,colour):
  - 0: 0,0,160,120,000
  - 1: 0,0,160,120,001
  - 2..16 (note blocks): 5+10*(cmd-2),40,8,4,110
  - 17: 140,0,20,15,010
  - 18: 140,15,20,15,010
  - 19 (background): 0,0,160,120; colour from choose: 00->000, 01->001, 10->011, 11->100
  - 20 (play clear): 0,60,160,1,000
  - 23: 30,44,1,32,011
  - 24: 38,44,1,32,011
  - 25: 34,44,1,32,101
  - 21, 22: legal no-ops
  - 26..31: illegal. Treated as no-op and set err; err clears only on reset.
- Arithmetic: counters cx 8 bits and cy 7 bits. Coordinate sums are computed 9 bits wide, then truncated to port width.

## Timing
- Handshake accepted at edge N. LOAD during cycle N+1. First plot in cycle N+2. Last plot in cycle N+1+w*h. done in cycle N+2+w*h. cmd_ready returns high in cycle N+3+w*h.
- No-op: done in cycle N+2, cmd_ready high in cycle N+3.
- Full-screen command: 19200 plot cycles, done at N+19202.
- Reset asserted mid-DRAW: the outputs take their reset values at that edge; no further plot pulses occur.
- x/y/colour hold their last value outside DRAW. Consumers qualify them with plot only.

## Configuration
- DRAW_EXEC_CLIP_EN defined: in DRAW, a pixel with x>=SCR_W or y>=SCR_H drives plot=0. That cycle is still consumed, so timing is unchanged.
- DRAW_EXEC_CLIP_EN undefined: no comparators. Table entries are guaranteed in-range and plot=1 throughout DRAW.

## Structure
- Package draw_cmd_pkg holds:
  - the command code localparams (0..25), matching the sequencer encoding
  - SCR_W/SCR_H defaults
  - the rect struct typedef {x0,y0,w,h,col}
  - the function cmd_to_rect(cmd, choose) and the function is_noop(cmd)
- One sub-module, draw_rect_raster: start, x0, y0, w, h in; x, y, active, last out. It holds the cx/cy counters. The executor owns the FSM, the handshake and the err/done logic.

## Test plan
- cmd=2, choose=00 accepted at edge 0 -> 32 plots, x 5..12, y 40..43 row-major, colour 110; done at cycle 34.
- cmd=19, choose=11 -> 19200 plots, colour 100, first (0,0), last (159,119); done at cycle 19202.
- cmd=22 -> zero plots, done at cycle 2, err=0. Then cmd=28 -> zero plots, done, err=1, and err stays 1 across the next legal command.
- cmd_valid held with cmd=23 during a cmd=2 draw -> cmd_ready=0 and the command is ignored; cmd=23 is accepted only after done, then gives 32 plots at x=30, y 44..75.
- reset low at plot 10 of cmd=17 -> plot=0, cmd_ready=1, err=0 next cycle; a subsequent cmd=18 gives 300 plots, y 15..29.
- With DRAW_EXEC_CLIP_EN, a test-only table override of x0=155, w=8 -> plot is high only for x 155..159, and done timing is unchanged.
